console_history_controller: RTL

Sequences the text console's line store and screen character writes. Keeps a scrolling history of committed PS/2 command lines and, on request, streams the full console (history plus the live edit line) into the screen character memory one character per cycle. It sits between the PS/2 line assembler and the VGA character RAM, and gives the top-level sequencer a start/done handshake.

---
 rtl/console_history_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/console_history_controller.sv
// Console line store and screen streamer: keeps a scrolling history of committed
// lines and rewrites history plus the live edit line into screen RAM on request.
module console_history_controller #(
  parameter int NUM_LINES     = 8,
  parameter int LINE_CHARS    = 32,
  parameter int VISIBLE_CHARS = 12,
  parameter int CHAR_W        = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [LINE_CHARS*CHAR_W-1:0] line_content,
  input  logic                         line_commit,
  output logic                         commit_ack,
  input  logic                         refresh_start,
  output logic                         scr_we,
  output logic [7:0]                   scr_addr,
  output logic [CHAR_W-1:0]            scr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int HIST       = NUM_LINES - 1;
  localparam int ROW_W      = $clog2(NUM_LINES);
  localparam int COL_W      = $clog2(VISIBLE_CHARS);
  localparam int CHAR_IDX_W = $clog2(LINE_CHARS);

  typedef enum logic [1:0] {IDLE, SCROLL, REFRESH, DONE} state_t;

  state_t             r_state, w_nextState;
  logic [CHAR_W-1:0]  w_lineChars [LINE_CHARS];
  logic [CHAR_W-1:0]  r_hist      [HIST][LINE_CHARS];
  logic [CHAR_W-1:0]  r_stage     [LINE_CHARS];
  logic [CHAR_W-1:0]  r_liveSnap  [VISIBLE_CHARS];
  logic               r_commitPending, r_refreshPending;
  logic [ROW_W-1:0]   r_row, r_scrollIdx;
  logic [COL_W-1:0]   r_col;
  logic               r_scrWe, r_busy, r_done, r_commitAck;
  logic [7:0]         r_scrAddr;
  logic [CHAR_W-1:0]  r_scrData;
  logic               w_lastCol, w_lastRow, w_lastScroll;
  logic [7:0]         w_addr;
  logic [CHAR_W-1:0]  w_char;

  // Column 0 sits in the most significant byte of the flat line bus.
  always_comb begin
    for (int c = 0; c < LINE_CHARS; c++)
      w_lineChars[c] = line_content[(LINE_CHARS-1-c)*CHAR_W +: CHAR_W];
  end

  assign w_lastCol    = (r_col == COL_W'(VISIBLE_CHARS-1));
  assign w_lastRow    = (r_row == ROW_W'(NUM_LINES-1));
  assign w_lastScroll = (r_scrollIdx == ROW_W'(HIST-1));
  assign w_addr       = 8'(r_row) * 8'(LINE_CHARS) + 8'(r_col);
  assign w_char       = w_lastRow ? r_liveSnap[r_col]
                                  : r_hist[r_row][CHAR_IDX_W'(r_col)];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (r_commitPending)       w_nextState = SCROLL;
        else if (r_refreshPending) w_nextState = REFRESH;
      end
      SCROLL:  if (w_lastScroll) w_nextState = IDLE;
      REFRESH: if (w_lastRow && w_lastCol) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A refresh pulse landing on the cycle its request is taken merges into that pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < HIST; r++)
        for (int c = 0; c < LINE_CHARS; c++) r_hist[r][c] <= '0;
      for (int c = 0; c < LINE_CHARS; c++) r_stage[c] <= '0;
      for (int c = 0; c < VISIBLE_CHARS; c++) r_liveSnap[c] <= '0;
      r_commitPending  <= 1'b0;
      r_refreshPending <= 1'b0;
      r_row            <= '0;
      r_col            <= '0;
      r_scrollIdx      <= '0;
      r_scrWe          <= 1'b0;
      r_scrAddr        <= '0;
      r_scrData        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_commitAck      <= 1'b0;
    end else begin
      r_scrWe     <= 1'b0;
      r_done      <= 1'b0;
      r_commitAck <= 1'b0;
      r_busy      <= (w_nextState != IDLE);
      if (line_commit && !r_commitPending) begin
        r_stage         <= w_lineChars;
        r_commitPending <= 1'b1;
        r_commitAck     <= 1'b1;
      end
      if (refresh_start) r_refreshPending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_commitPending) begin
            r_scrollIdx <= '0;
          end else if (r_refreshPending) begin
            r_refreshPending <= 1'b0;
            for (int c = 0; c < VISIBLE_CHARS; c++) r_liveSnap[c] <= w_lineChars[c];
            r_row <= '0;
            r_col <= '0;
          end
        end
        SCROLL: begin
          for (int k = 0; k < HIST-1; k++)
            if (r_scrollIdx == ROW_W'(k)) r_hist[k] <= r_hist[k+1];
          if (w_lastScroll) begin
            r_hist[HIST-1]  <= r_stage;
            r_commitPending <= 1'b0;
          end else begin
            r_scrollIdx <= r_scrollIdx + 1'b1;
          end
        end
        REFRESH: begin
          r_scrWe   <= 1'b1;
          r_scrAddr <= w_addr;
          r_scrData <= w_char;
          if (w_lastCol) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        DONE:    r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign scr_we     = r_scrWe;
  assign scr_addr   = r_scrAddr;
  assign scr_data   = r_scrData;
  assign busy       = r_busy;
  assign done       = r_done;
  assign commit_ack = r_commitAck;

endmodule
